// File: rtl/bick_delay_cal.sv
`default_nettype none
// ============================================================================
// Module   : bick_delay_cal
// Function : Automatic calibration controller for the BICK delay-tap mux.
//            Sweeps taps 0..7, scores each tap with the frame checker, then
//            locks the centre of the longest passing window. Also provides
//            a manual tap override for bring-up while idle.
// Revision : 1.0 - initial release
// ============================================================================
module bick_delay_cal #(
    parameter int SETTLE_CYC  = 64,
    parameter int TRIALS      = 16,
    parameter int TIMEOUT     = 65535,
    parameter int DEFAULT_TAP = 0
) (
    input  logic       clk_300m,
    input  logic       rst_n,
    input  logic       cal_start,
    input  logic       chk_valid,
    input  logic       chk_err,
    input  logic       man_en,
    input  logic [2:0] man_setting,
    output logic [2:0] delay_setting,
    output logic       cal_busy,
    output logic       cal_done,
    output logic       cal_fail,
    output logic [7:0] pass_map
);

    localparam int c_set_w = $clog2(SETTLE_CYC + 1);
    localparam int c_trl_w = $clog2(TRIALS + 1);
    localparam int c_to_w  = $clog2(TIMEOUT + 1);

    localparam logic [c_set_w-1:0] c_settle_last = c_set_w'(SETTLE_CYC - 1);
    localparam logic [c_trl_w-1:0] c_trials      = c_trl_w'(TRIALS);
    localparam logic [c_to_w-1:0]  c_timeout     = c_to_w'(TIMEOUT);
    localparam logic [2:0]         c_default_tap = 3'(DEFAULT_TAP);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_NEXT    = 3'd3,
        ST_EVAL    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t               r_state,        w_state_nxt;
    logic [2:0]           r_tap,          w_tap_nxt;
    logic [c_set_w-1:0]   r_settle_cnt,   w_settle_cnt_nxt;
    logic [c_trl_w-1:0]   r_trial_cnt,    w_trial_cnt_nxt;
    logic [c_to_w-1:0]    r_to_cnt,       w_to_cnt_nxt;
    logic                 r_err,          w_err_nxt;
    logic [3:0]           r_eval_idx,     w_eval_idx_nxt;
    logic [2:0]           r_cur_start,    w_cur_start_nxt;
    logic [3:0]           r_cur_len,      w_cur_len_nxt;
    logic [2:0]           r_best_start,   w_best_start_nxt;
    logic [3:0]           r_best_len,     w_best_len_nxt;
    logic [2:0]           r_delay,        w_delay_nxt;
    logic                 r_busy,         w_busy_nxt;
    logic                 r_done,         w_done_nxt;
    logic                 r_fail,         w_fail_nxt;
    logic [7:0]           r_pass_map,     w_pass_map_nxt;

    logic                 w_eval_bit;
    logic [3:0]           w_run_len;
    logic [2:0]           w_run_start;
    logic [2:0]           w_offset;

    assign delay_setting = r_delay;
    assign cal_busy      = r_busy;
    assign cal_done      = r_done;
    assign cal_fail      = r_fail;
    assign pass_map      = r_pass_map;

    // Next-state and next-value logic for the whole calibration sequence
    always_comb begin
        w_state_nxt      = r_state;
        w_tap_nxt        = r_tap;
        w_settle_cnt_nxt = r_settle_cnt;
        w_trial_cnt_nxt  = r_trial_cnt;
        w_to_cnt_nxt     = r_to_cnt;
        w_err_nxt        = r_err;
        w_eval_idx_nxt   = r_eval_idx;
        w_cur_start_nxt  = r_cur_start;
        w_cur_len_nxt    = r_cur_len;
        w_best_start_nxt = r_best_start;
        w_best_len_nxt   = r_best_len;
        w_delay_nxt      = r_delay;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_fail_nxt       = r_fail;
        w_pass_map_nxt   = r_pass_map;

        // Window scan helpers: extend the current run, or open a new one here
        w_eval_bit  = r_pass_map[r_eval_idx[2:0]];
        w_run_len   = r_cur_len + 4'd1;
        w_run_start = (r_cur_len == 4'd0) ? r_eval_idx[2:0] : r_cur_start;
        // Centre of the best window rounds down for even lengths
        w_offset    = 3'((r_best_len - 4'd1) >> 1);

        case (r_state)
            ST_IDLE: begin
                if (cal_start) begin
                    w_tap_nxt        = 3'd0;
                    w_delay_nxt      = 3'd0;
                    w_pass_map_nxt   = 8'h00;
                    w_busy_nxt       = 1'b1;
                    w_settle_cnt_nxt = '0;
                    w_state_nxt      = ST_SETTLE;
                end else if (man_en) begin
                    w_delay_nxt = man_setting;
                end
            end

            ST_SETTLE: begin
                if (r_settle_cnt == c_settle_last) begin
                    w_err_nxt       = 1'b0;
                    w_trial_cnt_nxt = '0;
                    w_to_cnt_nxt    = '0;
                    w_state_nxt     = ST_MEASURE;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + 1'b1;
                end
            end

            ST_MEASURE: begin
                // Trial completion is checked first so it beats a coincident timeout;
                // a strobe arriving on the exit cycle is deliberately dropped.
                if (r_trial_cnt == c_trials) begin
                    w_pass_map_nxt[r_tap] = ~r_err;
                    w_state_nxt           = ST_NEXT;
                end else if (r_to_cnt == c_timeout) begin
                    w_pass_map_nxt[r_tap] = 1'b0;
                    w_state_nxt           = ST_NEXT;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                    if (chk_valid) begin
                        w_trial_cnt_nxt = r_trial_cnt + 1'b1;
                        if (chk_err) begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
            end

            ST_NEXT: begin
                w_settle_cnt_nxt = '0;
                if (r_tap == 3'd7) begin
                    w_eval_idx_nxt   = 4'd0;
                    w_cur_start_nxt  = 3'd0;
                    w_cur_len_nxt    = 4'd0;
                    w_best_start_nxt = 3'd0;
                    w_best_len_nxt   = 4'd0;
                    w_state_nxt      = ST_EVAL;
                end else begin
                    w_tap_nxt   = r_tap + 3'd1;
                    w_delay_nxt = r_tap + 3'd1;
                    w_state_nxt = ST_SETTLE;
                end
            end

            ST_EVAL: begin
                if (r_eval_idx == 4'd8) begin
                    if (r_best_len != 4'd0) begin
                        w_delay_nxt = r_best_start + w_offset;
                        w_fail_nxt  = 1'b0;
                    end else begin
                        w_delay_nxt = c_default_tap;
                        w_fail_nxt  = 1'b1;
                    end
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_eval_idx_nxt = r_eval_idx + 4'd1;
                    if (w_eval_bit) begin
                        w_cur_len_nxt   = w_run_len;
                        w_cur_start_nxt = w_run_start;
                        // Strictly longer only, so the earliest window keeps ties
                        if (w_run_len > r_best_len) begin
                            w_best_len_nxt   = w_run_len;
                            w_best_start_nxt = w_run_start;
                        end
                    end else begin
                        w_cur_len_nxt = 4'd0;
                    end
                end
            end

            ST_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_300m or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tap        <= 3'd0;
            r_settle_cnt <= '0;
            r_trial_cnt  <= '0;
            r_to_cnt     <= '0;
            r_err        <= 1'b0;
            r_eval_idx   <= 4'd0;
            r_cur_start  <= 3'd0;
            r_cur_len    <= 4'd0;
            r_best_start <= 3'd0;
            r_best_len   <= 4'd0;
            r_delay      <= c_default_tap;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_pass_map   <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_tap        <= w_tap_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_trial_cnt  <= w_trial_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_err        <= w_err_nxt;
            r_eval_idx   <= w_eval_idx_nxt;
            r_cur_start  <= w_cur_start_nxt;
            r_cur_len    <= w_cur_len_nxt;
            r_best_start <= w_best_start_nxt;
            r_best_len   <= w_best_len_nxt;
            r_delay      <= w_delay_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_fail       <= w_fail_nxt;
            r_pass_map   <= w_pass_map_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bick_delay_cal.sv
`default_nettype none
// ============================================================================
// Module   : tb_bick_delay_cal
// Function : Self-checking bench for bick_delay_cal. A stimulus process
//            plays the frame checker per tap; expected calibration results
//            are queued at cal_start and popped by a monitor on cal_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bick_delay_cal;

    localparam int SETTLE_CYC  = 8;
    localparam int TRIALS      = 16;
    localparam int TIMEOUT     = 100;
    localparam int DEFAULT_TAP = 2;
    localparam int CAL_BUDGET  = 3000;

    logic       clk_300m = 1'b0;
    logic       rst_n;
    logic       cal_start;
    logic       chk_valid;
    logic       chk_err;
    logic       man_en;
    logic [2:0] man_setting;
    logic [2:0] delay_setting;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_fail;
    logic [7:0] pass_map;

    typedef struct packed {
        logic [7:0] map;
        logic [2:0] tap;
        logic       fail;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] plan_err    = 8'h00;
    logic [7:0] plan_silent = 8'h00;
    int         n_tests     = 0;
    int         n_fail      = 0;
    logic       prev_done   = 1'b0;

    bick_delay_cal #(
        .SETTLE_CYC (SETTLE_CYC),
        .TRIALS     (TRIALS),
        .TIMEOUT    (TIMEOUT),
        .DEFAULT_TAP(DEFAULT_TAP)
    ) dut (
        .clk_300m     (clk_300m),
        .rst_n        (rst_n),
        .cal_start    (cal_start),
        .chk_valid    (chk_valid),
        .chk_err      (chk_err),
        .man_en       (man_en),
        .man_setting  (man_setting),
        .delay_setting(delay_setting),
        .cal_busy     (cal_busy),
        .cal_done     (cal_done),
        .cal_fail     (cal_fail),
        .pass_map     (pass_map)
    );

    always #2 clk_300m = ~clk_300m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a tap passes if it got errors on no frame and was not starved;
    // the chosen tap is the centre of the longest run, earliest run on ties.
    function automatic exp_t ref_model(input logic [7:0] err, input logic [7:0] silent);
        exp_t       e;
        logic [7:0] ok;
        int         best_s = 0;
        int         best_l = 0;
        ok = ~err & ~silent;
        for (int s = 0; s < 8; s++) begin
            int l = 0;
            while ((s + l) < 8 && ok[s + l]) l++;
            if (l > best_l) begin
                best_l = l;
                best_s = s;
            end
        end
        e.map  = ok;
        e.fail = (best_l == 0);
        e.tap  = (best_l == 0) ? 3'(DEFAULT_TAP) : 3'(best_s + (best_l - 1) / 2);
        return e;
    endfunction

    // Frame checker model: follows the tap on the mux, random frame spacing
    initial begin
        chk_valid = 1'b0;
        chk_err   = 1'b0;
        forever begin
            @(posedge clk_300m);
            #1;
            if (plan_silent[delay_setting]) begin
                chk_valid = 1'b0;
            end else begin
                chk_valid = 1'($urandom_range(0, 1));
            end
            if (chk_valid) chk_err = plan_err[delay_setting];
            else           chk_err = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: each cal_done pulse is matched to the oldest queued expectation
    initial begin
        forever begin
            @(negedge clk_300m);
            if (rst_n && cal_done) begin
                if (prev_done) check("done_single_cycle", 32'(prev_done), 32'd0);
                check("busy_at_done", 32'(cal_busy), 32'd1);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(cal_done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("pass_map", 32'(pass_map), 32'(e.map));
                    check("delay_setting", 32'(delay_setting), 32'(e.tap));
                    check("cal_fail", 32'(cal_fail), 32'(e.fail));
                end
            end
            prev_done = rst_n && cal_done;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_300m);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (cal_busy && cyc < CAL_BUDGET) begin
            tick(1);
            cyc++;
        end
        if (cal_busy) check({name, "_timeout"}, 32'(cal_busy), 32'd0);
        tick(2);
    endtask

    // Pulse cal_start and queue the expected outcome of the planned sweep
    task automatic start_cal(input logic [7:0] err, input logic [7:0] silent, input logic with_man);
        plan_err    = err;
        plan_silent = silent;
        sb_q.push_back(ref_model(err, silent));
        cal_start   = 1'b1;
        man_en      = with_man;
        man_setting = 3'd7;
        tick(1);
        cal_start = 1'b0;
        man_en    = 1'b0;
        check("busy_after_start", 32'(cal_busy), 32'd1);
        if (with_man) check("start_beats_manual", 32'(delay_setting), 32'd0);
    endtask

    task automatic run_cal(input string name, input logic [7:0] err, input logic [7:0] silent);
        start_cal(err, silent, 1'b0);
        wait_idle(name);
    endtask

    initial begin
        int cyc;
        rst_n       = 1'b0;
        cal_start   = 1'b0;
        man_en      = 1'b0;
        man_setting = 3'd0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        check("rst_delay", 32'(delay_setting), 32'(DEFAULT_TAP));
        check("rst_busy", 32'(cal_busy), 32'd0);
        check("rst_done", 32'(cal_done), 32'd0);
        check("rst_fail", 32'(cal_fail), 32'd0);
        check("rst_map", 32'(pass_map), 32'd0);

        // Manual override in idle
        man_en      = 1'b1;
        man_setting = 3'd5;
        tick(1);
        check("manual_apply", 32'(delay_setting), 32'd5);
        man_en = 1'b0;
        man_setting = 3'd1;
        tick(4);
        check("manual_hold", 32'(delay_setting), 32'd5);

        // Full pass sweep, cal_start coinciding with man_en
        start_cal(8'h00, 8'h00, 1'b1);
        wait_idle("full_pass");

        // Window selection
        run_cal("win_bc", 8'h43, 8'h00);
        run_cal("win_33", 8'hCC, 8'h00);

        // Starved checker: every tap times out
        run_cal("all_timeout", 8'h00, 8'hFF);
        check("fail_sticky", 32'(cal_fail), 32'd1);
        run_cal("recover", 8'h00, 8'h00);
        check("fail_cleared", 32'(cal_fail), 32'd0);

        // Busy lockout: start and manual override during MEASURE of tap 3
        start_cal(8'h81, 8'h00, 1'b0);
        cyc = 0;
        while (delay_setting != 3'd3 && cyc < CAL_BUDGET) begin
            tick(1);
            cyc++;
        end
        check("reach_tap3", 32'(delay_setting), 32'd3);
        tick(SETTLE_CYC + 4);
        cal_start   = 1'b1;
        man_en      = 1'b1;
        man_setting = 3'd6;
        tick(2);
        cal_start = 1'b0;
        tick(3);
        check("lockout_delay", 32'(delay_setting), 32'd3);
        man_en = 1'b0;
        wait_idle("lockout");

        // Asynchronous reset during SETTLE
        start_cal(8'h00, 8'h00, 1'b0);
        tick(3);
        #1;
        rst_n = 1'b0;
        #0.5;
        sb_q.delete();
        check("arst_delay", 32'(delay_setting), 32'(DEFAULT_TAP));
        check("arst_busy", 32'(cal_busy), 32'd0);
        check("arst_done", 32'(cal_done), 32'd0);
        check("arst_fail", 32'(cal_fail), 32'd0);
        check("arst_map", 32'(pass_map), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(SETTLE_CYC * 20);
        check("post_rst_idle", 32'(cal_busy), 32'd0);
        run_cal("post_rst_cal", 8'h18, 8'h00);

        // Randomized sweeps
        for (int r = 0; r < 6; r++) begin
            logic [7:0] e;
            logic [7:0] s;
            e = 8'($urandom) & 8'($urandom);
            s = 8'($urandom) & 8'($urandom) & 8'($urandom);
            run_cal("random", e, s);
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bick_delay_cal.md
Name: bick_delay_cal

Overview:
- Automatic calibration controller for the BICK delay-tap mux.
- Drives the mux's 3-bit delay_setting and sweeps taps 0..7. At each tap it counts the pass/fail results from the downstream frame checker, then locks the tap at the centre of the longest passing window.
- Sits beside the delay mux in the clk_300m domain.
- Provides a manual override for bring-up.

Parameters:
- SETTLE_CYC, 64: clk_300m cycles to wait after each tap change before checking starts.
- TRIALS, 16: number of checker results sampled per tap.
- TIMEOUT, 65535: maximum cycles allowed in MEASURE per tap; if exceeded, the tap is marked failed.
- DEFAULT_TAP, 0: tap applied when no tap passes.

Ports:
- clk_300m  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- cal_start  in  1  single-cycle pulse that starts calibration.
- chk_valid  in  1  checker result strobe, one cycle per frame.
- chk_err  in  1  checker error flag; qualified by chk_valid.
- man_en  in  1  manual override enable.
- man_setting  in  3  manual tap value.
- delay_setting  out  3  tap select driven to the delay mux.
- cal_busy  out  1  high while calibration is in progress.
- cal_done  out  1  one-cycle pulse when calibration completes.
- cal_fail  out  1  sticky flag: last calibration found no passing tap.
- pass_map  out  8  bit i = tap i passed in the last calibration.

Behaviour:
- Reset values: delay_setting=DEFAULT_TAP, cal_busy=0, cal_done=0, cal_fail=0, pass_map=0, FSM=IDLE, all counters 0.
- All outputs are registered.
- IDLE:
  - If man_en=1, delay_setting<=man_setting, visible 1 cycle later.
  - Otherwise delay_setting holds its value.
  - cal_start=1 -> tap<=0, delay_setting<=0, pass_map<=0, cal_busy<=1, go to SETTLE.
  - If cal_start and man_en are both high, cal_start wins.
- SETTLE: count SETTLE_CYC cycles; chk_valid is ignored. Then clear err_cnt, trial_cnt and to_cnt, and go to MEASURE.
- MEASURE:
  - Each chk_valid increments trial_cnt; if chk_err is also set, it increments err_cnt (saturating at 1 is acceptable).
  - to_cnt increments every cycle.
  - Exit when trial_cnt reaches TRIALS: tap passes iff err_cnt==0.
  - Exit when to_cnt reaches TIMEOUT: tap fails.
  - If both conditions occur in the same cycle, the TRIALS result wins.
  - On exit, write pass_map[tap] and go to NEXT.
- NEXT: if tap==7, go to EVAL. Otherwise tap<=tap+1, delay_setting<=tap+1, go to SETTLE.
- EVAL:
  - Scan pass_map bits 0..7, one bit per cycle (8 cycles), tracking the current run and the best run (start, length).
  - Windows do not wrap: tap 7 and tap 0 are not adjacent.
  - Tie on length: the lowest start index wins.
  - On the 9th cycle:
    - If best_len>0: delay_setting<=best_start+((best_len-1)>>1), cal_fail<=0.
    - Otherwise: delay_setting<=DEFAULT_TAP, cal_fail<=1.
  - Then go to DONE.
- DONE: cal_done=1 for exactly one cycle, cal_busy<=0, go to IDLE.
- While cal_busy=1, cal_start and man_en are ignored.
- Latency from cal_start to cal_done for taps that complete within TRIALS: 8 x (1 + SETTLE_CYC + measure cycles + 1) + 9 + 1 cycles.
- A chk_valid arriving in the same cycle as the MEASURE exit is not counted.
- Reset asserted mid-calibration: immediate return to reset values, no cal_done pulse, and the pass_map from before the reset is lost.

Test Plan:
- Reset then idle:
  - Response: delay_setting=0, cal_busy=0, pass_map=0x00.
  - Stimulus: man_en=1, man_setting=5.
  - Response: delay_setting=5 one cycle later.
  - Stimulus: man_en=0.
  - Response: value held at 5.
- Full pass sweep:
  - Stimulus: checker returns chk_err=0 always, chk_valid every 20 cycles, cal_start pulse.
  - Response: pass_map=0xFF, delay_setting=3 (start 0, len 8 -> 0+3), cal_fail=0, single cal_done pulse, cal_busy high throughout.
- Window select:
  - Stimulus: errors injected on taps 0, 1 and 6.
  - Response: pass_map=0xBC (passing runs 2-5 len 4 and 7 len 1), delay_setting=3.
  - Stimulus: pass pattern 0x33 (runs 0-1 and 4-5, equal length).
  - Response: delay_setting=0 (lowest-start run wins).
- All fail / timeout:
  - Stimulus: DEFAULT_TAP=2, chk_valid never asserted, TIMEOUT reduced to 100.
  - Response: every tap times out, pass_map=0x00, cal_fail=1, delay_setting=2.
  - Stimulus: a later passing calibration.
  - Response: cal_fail clears to 0.
- Busy lockout and restart:
  - Stimulus: cal_start and man_en=1 asserted during MEASURE of tap 3.
  - Response: no effect.
- Reset mid-operation:
  - Stimulus: rst_n asserted low during SETTLE.
  - Response: all outputs go to reset values asynchronously, no cal_done pulse.
  - Stimulus: a new cal_start after reset.
  - Response: calibration completes normally.
